// File: rtl/issue_scoreboard.sv
// Parametrised scoreboard: in-order issue, out-of-order writeback, in-order commit.
// Tracks busy destination registers; a pipeline flush empties it.
// Optional macro SB_FORWARD_EN adds a youngest-writer operand forwarding search.
module issue_scoreboard #(
  parameter int unsigned NR_ENTRIES    = 8,
  parameter int unsigned NR_WB_PORTS   = 3,
  parameter int unsigned TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic                                   issue_valid_i,
  output logic                                   issue_ready_o,
  input  logic [63:0]                            issue_pc_i,
  input  logic [4:0]                             issue_rd_i,
  output logic [TRANS_ID_BITS-1:0]               issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
  input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]   wb_trans_id_i,
  input  logic [NR_WB_PORTS*64-1:0]              wb_result_i,
  input  logic [NR_WB_PORTS-1:0]                 wb_ex_valid_i,
  input  logic [NR_WB_PORTS*64-1:0]              wb_ex_cause_i,
  output logic                                   commit_valid_o,
  input  logic                                   commit_ack_i,
  output logic [TRANS_ID_BITS-1:0]               commit_trans_id_o,
  output logic [63:0]                            commit_pc_o,
  output logic [4:0]                             commit_rd_o,
  output logic [63:0]                            commit_result_o,
  output logic                                   commit_ex_valid_o,
  output logic [63:0]                            commit_ex_cause_o,
  input  logic [4:0]                             rs_addr_i,
  output logic                                   rs_busy_o,
  output logic                                   rs_fwd_valid_o,
  output logic [63:0]                            rs_fwd_data_o
);

  localparam int unsigned CNT_W = TRANS_ID_BITS + 1;

  logic [NR_ENTRIES-1:0]    occupied_q, done_q, ex_valid_q;
  logic [63:0]              pc_q       [NR_ENTRIES];
  logic [4:0]               rd_q       [NR_ENTRIES];
  logic [63:0]              result_q   [NR_ENTRIES];
  logic [63:0]              ex_cause_q [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0] issue_ptr_q, commit_ptr_q;
  logic [CNT_W-1:0]         count_q;

  logic                     issue_fire, commit_fire;
  logic [NR_ENTRIES-1:0]    wb_en, wb_exv;
  logic [63:0]              wb_res     [NR_ENTRIES];
  logic [63:0]              wb_exc     [NR_ENTRIES];

  // A commit in this cycle deliberately does not free space for this cycle's issue.
  assign issue_ready_o    = (count_q != CNT_W'(NR_ENTRIES));
  assign issue_trans_id_o = issue_ptr_q;
  assign issue_fire       = issue_valid_i && issue_ready_o;
  assign commit_fire      = commit_valid_o && commit_ack_i;

  // Head entry presented to the commit stage.
  assign commit_valid_o    = occupied_q[commit_ptr_q] && done_q[commit_ptr_q];
  assign commit_trans_id_o = commit_ptr_q;
  assign commit_pc_o       = pc_q[commit_ptr_q];
  assign commit_rd_o       = rd_q[commit_ptr_q];
  assign commit_result_o   = result_q[commit_ptr_q];
  assign commit_ex_valid_o = ex_valid_q[commit_ptr_q];
  assign commit_ex_cause_o = ex_cause_q[commit_ptr_q];

  // Per-entry writeback select; scanning ports high to low lets the lowest port win.
  always_comb begin
    wb_en  = '0;
    wb_exv = '0;
    for (int i = 0; i < int'(NR_ENTRIES); i++) begin
      wb_res[i] = '0;
      wb_exc[i] = '0;
      for (int p = int'(NR_WB_PORTS) - 1; p >= 0; p--) begin
        if (wb_valid_i[p] &&
            wb_trans_id_i[p*TRANS_ID_BITS +: TRANS_ID_BITS] == TRANS_ID_BITS'(i)) begin
          wb_en[i]  = 1'b1;
          wb_res[i] = wb_result_i[p*64 +: 64];
          wb_exv[i] = wb_ex_valid_i[p];
          wb_exc[i] = wb_ex_cause_i[p*64 +: 64];
        end
      end
    end
  end

  // Entry storage, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      occupied_q   <= '0;
      done_q       <= '0;
      ex_valid_q   <= '0;
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        pc_q[i]       <= '0;
        rd_q[i]       <= '0;
        result_q[i]   <= '0;
        ex_cause_q[i] <= '0;
      end
    end else if (flush_i) begin
      occupied_q   <= '0;
      done_q       <= '0;
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
    end else begin
      for (int i = 0; i < int'(NR_ENTRIES); i++) begin
        if (wb_en[i] && occupied_q[i]) begin
          done_q[i]     <= 1'b1;
          result_q[i]   <= wb_res[i];
          ex_valid_q[i] <= wb_exv[i];
          ex_cause_q[i] <= wb_exc[i];
        end
      end
      if (issue_fire) begin
        occupied_q[issue_ptr_q] <= 1'b1;
        done_q[issue_ptr_q]     <= 1'b0;
        ex_valid_q[issue_ptr_q] <= 1'b0;
        pc_q[issue_ptr_q]       <= issue_pc_i;
        rd_q[issue_ptr_q]       <= issue_rd_i;
        issue_ptr_q             <= issue_ptr_q + TRANS_ID_BITS'(1);
      end
      if (commit_fire) begin
        occupied_q[commit_ptr_q] <= 1'b0;
        done_q[commit_ptr_q]     <= 1'b0;
        commit_ptr_q             <= commit_ptr_q + TRANS_ID_BITS'(1);
      end
      count_q <= count_q + CNT_W'(issue_fire) - CNT_W'(commit_fire);
    end
  end

`ifdef SB_FORWARD_EN
  logic                     fwd_found;
  logic [TRANS_ID_BITS-1:0] fwd_sel, fwd_idx;

  // Walk from oldest to youngest; the last match is the youngest writer.
  always_comb begin
    fwd_found = 1'b0;
    fwd_sel   = '0;
    fwd_idx   = '0;
    for (int k = 0; k < int'(NR_ENTRIES); k++) begin
      fwd_idx = commit_ptr_q + TRANS_ID_BITS'(k);
      if ((CNT_W'(k) < count_q) && occupied_q[fwd_idx] &&
          (rd_q[fwd_idx] == rs_addr_i) && (rs_addr_i != 5'd0)) begin
        fwd_found = 1'b1;
        fwd_sel   = fwd_idx;
      end
    end
  end

  assign rs_busy_o      = fwd_found && !done_q[fwd_sel];
  assign rs_fwd_valid_o = fwd_found && done_q[fwd_sel] && !ex_valid_q[fwd_sel];
  assign rs_fwd_data_o  = rs_fwd_valid_o ? result_q[fwd_sel] : 64'd0;
`else
  // Any pending unfinished writer of the queried register.
  always_comb begin
    rs_busy_o = 1'b0;
    for (int i = 0; i < int'(NR_ENTRIES); i++) begin
      if (occupied_q[i] && !done_q[i] && (rd_q[i] == rs_addr_i) && (rs_addr_i != 5'd0))
        rs_busy_o = 1'b1;
    end
  end

  assign rs_fwd_valid_o = 1'b0;
  assign rs_fwd_data_o  = 64'd0;
`endif

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
- Parametrised in-order-issue, out-of-order-writeback, in-order-commit scoreboard.
- Successor to the fixed 4-entry, 3-writeback-port scoreboard layout. Depth and writeback port count are now generics.
- Adds destination-register busy tracking, optional operand forwarding, and a pipeline flush.
- Sits between the issue stage, the functional units (writeback) and the commit stage.

Parameters:
- NR_ENTRIES, 8: scoreboard depth. Must be a power of two and at least 2.
- NR_WB_PORTS, 3: number of independent writeback ports.
- TRANS_ID_BITS, $clog2(NR_ENTRIES): derived entry-index width. Not to be overridden.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all entries
- issue_valid_i  in  1  issue request
- issue_ready_o  out  1  free entry available
- issue_pc_i  in  64  PC of issued instruction
- issue_rd_i  in  5  destination register
- issue_trans_id_o  out  TRANS_ID_BITS  index the issued instruction will occupy
- wb_valid_i  in  NR_WB_PORTS  per-port writeback strobe
- wb_trans_id_i  in  NR_WB_PORTS*TRANS_ID_BITS  target entry per port
- wb_result_i  in  NR_WB_PORTS*64  result per port
- wb_ex_valid_i  in  NR_WB_PORTS  exception flag per port
- wb_ex_cause_i  in  NR_WB_PORTS*64  exception cause per port
- commit_valid_o  out  1  head entry finished
- commit_ack_i  in  1  commit stage consumes head
- commit_trans_id_o  out  TRANS_ID_BITS  head index
- commit_pc_o  out  64  head PC
- commit_rd_o  out  5  head rd
- commit_result_o  out  64  head result
- commit_ex_valid_o  out  1  head exception flag
- commit_ex_cause_o  out  64  head exception cause
- rs_addr_i  in  5  register to query
- rs_busy_o  out  1  pending unfinished writer of rs_addr_i
- rs_fwd_valid_o  out  1  forwardable value present
- rs_fwd_data_o  out  64  forwarded value

Behaviour:
- **Storage:** circular buffer. State is issue_ptr, commit_ptr and count (TRANS_ID_BITS+1 bits). Each entry holds occupied, done, pc, rd, result, ex_valid, ex_cause.
- **Reset (rst_ni low, asynchronous):** all occupied/done bits, both pointers and count go to 0. Resulting outputs: issue_ready_o=1, issue_trans_id_o=0, commit_valid_o=0, rs_busy_o=0, rs_fwd_valid_o=0. Data outputs are 0.
- **Issue readiness:** issue_ready_o = (count != NR_ENTRIES), combinational from registered count.
  - A commit in the same cycle does not free space for that cycle's issue.
  - A full buffer therefore stalls issue for one cycle after a commit.
- **Issue handshake:** on issue_valid_i && issue_ready_o, entry[issue_ptr] is written. occupied=1, done=0, pc/rd stored, ex_valid=0. issue_ptr increments and wraps modulo NR_ENTRIES. issue_trans_id_o always equals issue_ptr.
- **Writeback:**
  - For each port p with wb_valid_i[p], entry[wb_trans_id_i[p]] takes the result, ex_valid and ex_cause, and done is set.
  - If two ports target the same index in one cycle, the lowest p wins.
  - A writeback to an unoccupied entry is ignored.
  - A writeback to an already-done entry overwrites it.
- **Commit outputs:** commit_valid_o = occupied[commit_ptr] && done[commit_ptr]. All commit_* outputs are driven combinationally from entry[commit_ptr].
  - Writeback-to-commit_valid latency is 1 cycle (registered done).
  - Earliest writeback is the cycle after issue.
- **Commit handshake:** on commit_valid_o && commit_ack_i, entry[commit_ptr] has occupied and done cleared, and commit_ptr increments with wrap. commit_ack_i without commit_valid_o is ignored.
- **Count update:** count_next = count + issue_fire - commit_fire. Simultaneous issue and commit leaves count unchanged.
- **Flush:** flush_i is synchronous and has priority over issue, writeback and commit in the same cycle. Next cycle, all entries are unoccupied and pointers/count are 0. issue_ready_o does not depend on flush_i.
- **Busy query:** rs_busy_o = (rs_addr_i != 0) && some occupied entry with rd == rs_addr_i has done == 0. Combinational.

Optional Feature:
- Macro: SB_FORWARD_EN.
- **Defined:**
  - The youngest occupied entry with rd == rs_addr_i (rs_addr_i != 0) is selected. Age order is counted backwards from issue_ptr-1 to commit_ptr.
  - If that entry is done and ex_valid == 0, rs_fwd_valid_o=1 and rs_fwd_data_o is its result.
  - Otherwise rs_fwd_valid_o=0.
  - rs_busy_o then reports only the youngest matching entry being not done.
- **Undefined:** rs_fwd_valid_o and rs_fwd_data_o are tied to 0, and no age-ordered search logic is built.

Test Plan:
- **Fill and overflow:** with NR_ENTRIES=8, issue 8 instructions back-to-back, then assert issue_valid_i on the 9th. Expected: trans_ids 0..7, issue_ready_o=0 after the 8th, count=8, and no write for the 9th.
- **Out-of-order writeback:** issue ids 0,1,2; write back 2, then 0, then 1 on different ports. Expected: commit_valid_o rises one cycle after id 0's writeback; commits occur in order 0,1,2 with the matching results.
- **Port collision:** ports 0 and 2 write id 3 in the same cycle with results 0xAAAA and 0x5555. Expected: stored result is 0xAAAA.
- **Wrap-around:** issue and commit 20 instructions with continuous flow. Expected: trans_id sequence wraps 7→0, results are correct, and count never exceeds 8.
- **Flush mid-operation:** 5 occupied entries, flush_i asserted together with issue_valid_i and commit_ack_i. Expected next cycle: count=0, commit_valid_o=0, issue_trans_id_o=0, rs_busy_o=0.
- **Forwarding (SB_FORWARD_EN):** issue rd=x5 twice (ids 0 and 1); write back id 0 with 0x11, then id 1 with 0x22; query rs_addr_i=5. Expected after id 0's writeback: busy=1, fwd_valid=0. Expected after id 1's writeback: fwd_valid=1, data=0x22. Query rs_addr_i=0: busy=0.
